// File: rtl/bus_demux_pkg.sv
// Shared types and constants for the three-target bus demultiplexer.
package bus_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [1:0] T0       = 2'b00;
    localparam logic [1:0] T1       = 2'b01;
    localparam logic [1:0] T2       = 2'b10;
    localparam logic [1:0] UNMAPPED = 2'b11;

    function automatic logic [2:0] tgt_onehot(input logic [1:0] code);
        logic [2:0] oh;
        case (code)
            T0:      oh = 3'b001;
            T1:      oh = 3'b010;
            T2:      oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/module_bus_demux3_sel3.sv
// 3:1 data selector driven by a 2-bit target code; the unused code yields zero.
module bus_demux_sel3
    import bus_demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    output logic [WIDTH-1:0] y_o
);

    // Select one of the three inputs by target code.
    always_comb begin
        y_o = {WIDTH{1'b0}};
        case (sel_i)
            T0:      y_o = in0_i;
            T1:      y_o = in1_i;
            T2:      y_o = in2_i;
            default: y_o = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/module_bus_demux3.sv
// Single-outstanding bus demultiplexer: routes one request to one of three
// targets by the top address bits, with timeout and unmapped-address errors.
module module_bus_demux3
    import bus_demux_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [2:0]            t_sel_o,
    output logic                  t_we_o,
    output logic [ADDR_WIDTH-1:0] t_addr_o,
    output logic [DATA_WIDTH-1:0] t_wdata_o,
    input  logic [DATA_WIDTH-1:0] t_rdata0_i,
    input  logic [DATA_WIDTH-1:0] t_rdata1_i,
    input  logic [DATA_WIDTH-1:0] t_rdata2_i,
    input  logic [2:0]            t_ack_i
);

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_nxt;
    logic [1:0]            r_tgt;
    logic [1:0]            w_tgt_nxt;
    logic [1:0]            w_code;
    logic [2:0]            w_sel_nxt;
    logic                  w_we_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic                  w_valid_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic                  w_err_nxt;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_ack_hit;

    assign w_code      = req_addr_i[ADDR_WIDTH-1:ADDR_WIDTH-2];
    assign req_ready_o = (r_state == IDLE);
    // Only the ack of the currently selected target counts; others are masked.
    assign w_ack_hit   = |(t_ack_i & t_sel_o);

    bus_demux_sel3 #(
        .WIDTH (DATA_WIDTH)
    ) u_sel (
        .sel_i (r_tgt),
        .in0_i (t_rdata0_i),
        .in1_i (t_rdata1_i),
        .in2_i (t_rdata2_i),
        .y_o   (w_sel_rdata)
    );

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt;
        w_sel_nxt   = t_sel_o;
        w_we_nxt    = t_we_o;
        w_addr_nxt  = t_addr_o;
        w_wdata_nxt = t_wdata_o;
        w_valid_nxt = rsp_valid_o;
        w_rdata_nxt = rsp_rdata_o;
        w_err_nxt   = rsp_err_o;
        case (r_state)
            IDLE: begin
                w_sel_nxt   = 3'b000;
                w_valid_nxt = 1'b0;
                if (req_valid_i) begin
                    w_we_nxt    = req_we_i;
                    w_addr_nxt  = req_addr_i;
                    w_wdata_nxt = req_wdata_i;
                    w_tgt_nxt   = w_code;
                    w_cnt_nxt   = 8'd0;
                    if (w_code == UNMAPPED) begin
                        w_state_nxt = RESP;
                        w_valid_nxt = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = {DATA_WIDTH{1'b0}};
                    end else begin
                        w_state_nxt = WAIT;
                        w_sel_nxt   = tgt_onehot(w_code);
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                // An ack on the last counted cycle still beats the timeout.
                if (w_ack_hit) begin
                    w_state_nxt = RESP;
                    w_sel_nxt   = 3'b000;
                    w_valid_nxt = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_rdata_nxt = t_we_o ? {DATA_WIDTH{1'b0}} : w_sel_rdata;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = RESP;
                    w_sel_nxt   = 3'b000;
                    w_valid_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = {DATA_WIDTH{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_rdata_nxt = {DATA_WIDTH{1'b0}};
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = 3'b000;
                w_valid_nxt = 1'b0;
                w_err_nxt   = 1'b0;
                w_rdata_nxt = {DATA_WIDTH{1'b0}};
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_tgt       <= T0;
            t_sel_o     <= 3'b000;
            t_we_o      <= 1'b0;
            t_addr_o    <= {ADDR_WIDTH{1'b0}};
            t_wdata_o   <= {DATA_WIDTH{1'b0}};
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= {DATA_WIDTH{1'b0}};
            rsp_err_o   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tgt       <= w_tgt_nxt;
            t_sel_o     <= w_sel_nxt;
            t_we_o      <= w_we_nxt;
            t_addr_o    <= w_addr_nxt;
            t_wdata_o   <= w_wdata_nxt;
            rsp_valid_o <= w_valid_nxt;
            rsp_rdata_o <= w_rdata_nxt;
            rsp_err_o   <= w_err_nxt;
        end
    end

endmodule

// File: doc/module_bus_demux3.md
MODULE_BUS_DEMUX3 -- requirements
Module: module_bus_demux3

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT, 16, max WAIT cycles before error; legal range 2..255.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i  in  1  single clock; all state on rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  initiator request valid.
- req_ready_o  out  1  block accepts request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  request address.
- req_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  initiator accepts response.
- rsp_rdata_o  out  DATA_WIDTH  read data.
- rsp_err_o  out  1  unmapped or timeout.
- t_sel_o  out  3  one-hot target select.
- t_we_o  out  1  registered write enable.
- t_addr_o  out  ADDR_WIDTH  registered address.
- t_wdata_o  out  DATA_WIDTH  registered write data.
- t_rdata0_i / t_rdata1_i / t_rdata2_i  in  DATA_WIDTH each  per-target read data.
- t_ack_i  in  3  per-target completion.

Function
REQ-003 Target decode SHALL use req_addr_i[ADDR_WIDTH-1:ADDR_WIDTH-2]:
- 00 -> target 0; 01 -> target 1; 10 -> target 2.
- 11 -> unmapped.

REQ-004 The FSM SHALL have three states: IDLE, WAIT, RESP.

REQ-005 In IDLE, the block SHALL:
- Drive req_ready_o=1 and t_sel_o=0.
- On req_valid_i=1, capture we/addr/wdata into the t_*_o registers and the decoded target.

REQ-006 From IDLE with a mapped address, the next state SHALL be WAIT, with t_sel_o one-hot on the decoded target from the next cycle on.

REQ-007 From IDLE with an unmapped address, the next state SHALL be RESP with rsp_err_o=1 and rsp_rdata_o=0; no target is selected at any point.

REQ-008 In WAIT and RESP, req_ready_o SHALL be 0; at most one request is outstanding.

REQ-009 In WAIT, a cycle counter SHALL increment from 0 each cycle. On t_ack_i of the selected target the block SHALL:
- Capture that target's rdata into rsp_rdata_o (0 for writes).
- Set rsp_err_o=0.
- Go to RESP and clear t_sel_o.

REQ-010 t_ack_i bits of non-selected targets SHALL be ignored in every state.

REQ-011 If the counter reaches TIMEOUT-1 without an ack, the block SHALL go to RESP with rsp_err_o=1 and rsp_rdata_o=0, and clear t_sel_o. If an ack arrives in that same cycle, the ack SHALL win.

REQ-012 In RESP, rsp_valid_o SHALL be 1 and rsp_rdata_o/rsp_err_o SHALL hold stable until rsp_ready_i=1; then the block SHALL return to IDLE.

REQ-013 Minimum latency SHALL be:
- Mapped request: accept cycle -> rsp_valid_o 2 cycles later when the ack comes in the first WAIT cycle.
- Unmapped request: 1 cycle.

REQ-014 rsp_valid_o and t_sel_o SHALL be registered outputs with no combinational path from any input. req_ready_o SHALL be a pure decode of the state.

Reset
REQ-015 When rst_n_i=0, the block SHALL immediately, regardless of clock or state:
- Enter IDLE.
- Clear t_sel_o, t_we_o, t_addr_o, t_wdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o and the counter to 0.

REQ-016 Reset during WAIT or RESP SHALL drop the in-flight transaction with no response. req_ready_o SHALL be 1 in the first cycle after deassertion.

Structure
REQ-017 A shared package bus_demux_pkg SHALL hold:
- The state enum (IDLE, WAIT, RESP).
- The 2-bit target-code constants (T0=00, T1=01, T2=10, UNMAPPED=11).

REQ-018 Target read-data selection SHALL reuse the existing 3:1 selector module, instantiated once with WIDTH=DATA_WIDTH. There SHALL be no other sub-modules.

Verification
REQ-019 Read, addr 0x4000_0010, target 1 acks in 1st WAIT cycle with rdata 0xDEAD_BEEF -> t_sel_o=010 for one cycle; rsp_valid_o=1, rsp_rdata_o=0xDEAD_BEEF, rsp_err_o=0.

REQ-020 Write, addr 0x8000_0004, wdata 0x1234_5678, target 2 acks after 3 cycles -> t_we_o=1, t_wdata_o=0x1234_5678, t_sel_o=100 for 3 cycles; rsp_err_o=0.

REQ-021 Read, addr 0xC000_0000 -> t_sel_o stays 000; rsp_valid_o=1 one cycle after accept; rsp_err_o=1, rsp_rdata_o=0.

REQ-022 Read to target 0, TIMEOUT=16, no ack; target 1 acks throughout -> rsp_err_o=1 after 16 WAIT cycles; the target-1 acks are ignored.

REQ-023 Target-0 ack on the timeout cycle -> rsp_err_o=0 with target-0 rdata. Separately, rsp_ready_i held 0 for 5 cycles -> response held stable, then IDLE.

REQ-024 rst_n_i pulsed low mid-WAIT -> all outputs 0 asynchronously; rsp_valid_o never asserts for the dropped request; req_ready_o=1 after release.
